// File: rtl/uart_tx_serializer.sv
// -----------------------------------------------------------------------------
// uart_tx_serializer
//
// UART transmit serializer. The square-wave baud clock from clock_divider is
// sampled as ordinary data in the clk_in domain; each rising edge becomes a
// one-cycle bit tick. A byte accepted over valid/ready is sent LSB-first as
// start bit, DATA_BITS data bits, optional parity bit and STOP_BITS stop bits.
//
// Parameters:
//   DATA_BITS  data bits per frame (5..9)
//   PARITY_EN  1 inserts a parity bit after the data bits
//   PARITY_ODD 0 even parity, 1 odd parity (ignored when PARITY_EN=0)
//   STOP_BITS  number of stop bits (1 or 2)
//
// Ports:
//   clk_in    system clock, all logic on its rising edge
//   rst       synchronous active-high reset
//   baud_clk  baud square wave, sampled as data
//   tx_data   byte to send, sampled only on accept
//   tx_valid  producer holds tx_data valid
//   tx_ready  block can accept a byte this cycle
//   tx        serial line, idle high, registered
//   tx_busy   high from accept until the frame completes
//   tx_done   one-cycle pulse at frame completion
// -----------------------------------------------------------------------------
module uart_tx_serializer #(
   parameter int DATA_BITS  = 8,
   parameter int PARITY_EN  = 0,
   parameter int PARITY_ODD = 0,
   parameter int STOP_BITS  = 1
) (
   input  logic                 clk_in,
   input  logic                 rst,
   input  logic                 baud_clk,
   input  logic [DATA_BITS-1:0] tx_data,
   input  logic                 tx_valid,
   output logic                 tx_ready,
   output logic                 tx,
   output logic                 tx_busy,
   output logic                 tx_done
);

   if (DATA_BITS < 5 || DATA_BITS > 9) begin : g_bad_data_bits
      $error("uart_tx_serializer: DATA_BITS must be 5..9");
   end
   if (STOP_BITS < 1 || STOP_BITS > 2) begin : g_bad_stop_bits
      $error("uart_tx_serializer: STOP_BITS must be 1 or 2");
   end

   typedef enum logic [2:0] {
      S_IDLE,
      S_SYNC,
      S_START,
      S_DATA,
      S_PARITY,
      S_STOP
   } state_t;

   localparam int             CW        = (DATA_BITS > 8) ? 4 : 3;
   localparam logic [CW-1:0]  LAST_BIT  = CW'(DATA_BITS - 1);
   localparam logic           LAST_STOP = (STOP_BITS == 2);
   localparam logic           PODD      = (PARITY_ODD != 0);

   state_t                 state, state_nx;
   logic                   baud_q;
   logic                   tick;
   logic [DATA_BITS-1:0]   shift_q, shift_nx;
   logic [CW-1:0]          bit_cnt, bit_cnt_nx;
   logic                   stop_cnt, stop_cnt_nx;
   logic                   parity_q, parity_nx;
   logic                   tx_nx, busy_nx, done_nx;
   logic                   accept;

   // baud_q resets high so a baud_clk already high at reset release is not
   // mistaken for a rising edge.
   assign tick = baud_clk & ~baud_q;

   // The done cycle is still part of the finished frame: a producer holding
   // tx_valid is accepted the cycle after tx_done, never alongside it.
   assign tx_ready = (state == S_IDLE) && !tx_done;
   assign accept   = tx_valid && tx_ready;

   always_ff @(posedge clk_in) begin
      if (rst) begin
         state    <= S_IDLE;
         baud_q   <= 1'b1;
         shift_q  <= '0;
         bit_cnt  <= '0;
         stop_cnt <= 1'b0;
         parity_q <= 1'b0;
         tx       <= 1'b1;
         tx_busy  <= 1'b0;
         tx_done  <= 1'b0;
      end else begin
         state    <= state_nx;
         baud_q   <= baud_clk;
         shift_q  <= shift_nx;
         bit_cnt  <= bit_cnt_nx;
         stop_cnt <= stop_cnt_nx;
         parity_q <= parity_nx;
         tx       <= tx_nx;
         tx_busy  <= busy_nx;
         tx_done  <= done_nx;
      end
   end

   always_comb begin
      state_nx    = state;
      shift_nx    = shift_q;
      bit_cnt_nx  = bit_cnt;
      stop_cnt_nx = stop_cnt;
      parity_nx   = parity_q;
      tx_nx       = tx;
      busy_nx     = tx_busy;
      done_nx     = 1'b0;

      case (state)
         S_IDLE: begin
            // A tick coinciding with accept is deliberately dropped; SYNC
            // waits for the next one so the start bit is a full period.
            if (accept) begin
               shift_nx  = tx_data;
               parity_nx = (^tx_data) ^ PODD;
               busy_nx   = 1'b1;
               state_nx  = S_SYNC;
            end
         end
         S_SYNC: begin
            if (tick) begin
               tx_nx    = 1'b0;
               state_nx = S_START;
            end
         end
         S_START: begin
            if (tick) begin
               tx_nx      = shift_q[0];
               bit_cnt_nx = '0;
               state_nx   = S_DATA;
            end
         end
         S_DATA: begin
            if (tick) begin
               if (bit_cnt != LAST_BIT) begin
                  shift_nx   = shift_q >> 1;
                  tx_nx      = shift_q[1];
                  bit_cnt_nx = bit_cnt + 1'b1;
               end else if (PARITY_EN != 0) begin
                  tx_nx    = parity_q;
                  state_nx = S_PARITY;
               end else begin
                  tx_nx       = 1'b1;
                  stop_cnt_nx = 1'b0;
                  state_nx    = S_STOP;
               end
            end
         end
         S_PARITY: begin
            if (tick) begin
               tx_nx       = 1'b1;
               stop_cnt_nx = 1'b0;
               state_nx    = S_STOP;
            end
         end
         S_STOP: begin
            if (tick) begin
               if (stop_cnt != LAST_STOP) begin
                  stop_cnt_nx = stop_cnt + 1'b1;
               end else begin
                  tx_nx    = 1'b1;
                  busy_nx  = 1'b0;
                  done_nx  = 1'b1;
                  state_nx = S_IDLE;
               end
            end
         end
         default: begin
            state_nx = S_IDLE;
            tx_nx    = 1'b1;
            busy_nx  = 1'b0;
         end
      endcase
   end

endmodule

// File: tb/tb_uart_tx_serializer.sv
// -----------------------------------------------------------------------------
// tb_uart_tx_serializer
//
// Three serializer instances (8N1, 8E1, 8O2) share clock, reset, baud clock
// and data; each has its own valid. Accepted bytes are queued per instance;
// a per-instance line monitor rebuilds frames at each bit tick and compares
// them with the queue, and also checks tx_done timing and frame length.
// -----------------------------------------------------------------------------
module tb_uart_tx_serializer;

   localparam int N = 3;
   localparam int PE_T [N] = '{0, 1, 1};
   localparam int PO_T [N] = '{0, 0, 1};
   localparam int SB_T [N] = '{1, 1, 2};

   logic         clk   = 1'b0;
   logic         rst   = 1'b1;
   logic         baud  = 1'b0;
   logic         stuck = 1'b0;
   logic         len_en = 1'b1;
   logic [7:0]   data  = '0;
   logic [N-1:0] vld   = '0;
   logic [N-1:0] rdy, txl, busy, done, qempty;
   logic         b_q   = 1'b1;
   logic         tick_m;
   int           cyc   = 0;
   int           n_chk = 0;
   int           n_err = 0;

   always #5 clk = ~clk;

   // Baud square wave: rising edge every 4 clk cycles unless frozen.
   initial forever begin
      repeat (2) @(posedge clk);
      #1;
      if (!stuck) baud = ~baud;
   end

   always @(posedge clk) begin
      cyc <= cyc + 1;
      b_q <= rst ? 1'b1 : baud;
   end

   // Tick the DUT will see at the coming rising edge.
   assign tick_m = baud & ~b_q & ~rst;

   task automatic chk(input string tag, input int act, input int exp);
      n_chk++;
      if (act != exp) begin
         n_err++;
         $display("FAIL %s: got %0d want %0d (t=%0t)", tag, act, exp, $time);
      end
   endtask

   for (genvar i = 0; i < N; i++) begin : g
      localparam int PE    = PE_T[i];
      localparam int PO    = PO_T[i];
      localparam int SB    = SB_T[i];
      localparam int FRAME = 4 * (1 + 8 + PE + SB);

      uart_tx_serializer #(
         .DATA_BITS (8),
         .PARITY_EN (PE),
         .PARITY_ODD(PO),
         .STOP_BITS (SB)
      ) dut (
         .clk_in  (clk),
         .rst     (rst),
         .baud_clk(baud),
         .tx_data (data),
         .tx_valid(vld[i]),
         .tx_ready(rdy[i]),
         .tx      (txl[i]),
         .tx_busy (busy[i]),
         .tx_done (done[i])
      );

      logic [7:0] q[$];
      logic [7:0] got      = '0;
      logic [7:0] e        = '0;
      logic       pbit     = 1'b0;
      logic       done_nx  = 1'b0;
      logic       exp_done = 1'b0;
      logic       acc_prev = 1'b0;
      logic       empty    = 1'b1;
      int         ph = 0, cnt = 0, start_cyc = 0, acc_cyc = 0, done_cyc = 0;

      assign qempty[i] = empty;

      always @(negedge clk) begin
         exp_done = done_nx;
         done_nx  = 1'b0;
         chk($sformatf("done%0d", i), int'(done[i]), int'(exp_done));
         if (rst) begin
            ph       = 0;
            cnt      = 0;
            acc_prev = 1'b0;
            q.delete();
         end else begin
            if (acc_prev) chk($sformatf("busy_after_acc%0d", i), int'(busy[i]), 1);
            acc_prev = 1'b0;
            if (vld[i] && rdy[i]) begin
               q.push_back(data);
               acc_cyc  = cyc;
               acc_prev = 1'b1;
            end
            if (done[i]) done_cyc = cyc;
            if (exp_done) begin
               chk($sformatf("busy_at_done%0d", i), int'(busy[i]), 0);
               if (len_en) chk($sformatf("frame_len%0d", i), cyc - start_cyc, FRAME);
            end
            if (ph == 0 && txl[i]) start_cyc = cyc + 1;
            if (tick_m) begin
               case (ph)
                  0: if (!txl[i]) begin ph = 1; cnt = 0; end
                  1: begin
                     got[cnt] = txl[i];
                     cnt++;
                     if (cnt == 8) begin ph = (PE != 0) ? 2 : 3; cnt = 0; end
                  end
                  2: begin pbit = txl[i]; ph = 3; end
                  default: begin
                     chk($sformatf("stop%0d", i), int'(txl[i]), 1);
                     cnt++;
                     if (cnt == SB) begin
                        chk($sformatf("frame_expected%0d", i), int'(q.size() > 0), 1);
                        if (q.size() > 0) begin
                           e = q.pop_front();
                           chk($sformatf("data%0d", i), int'(got), int'(e));
                           if (PE != 0) chk($sformatf("parity%0d", i), int'(pbit), int'(^e) ^ PO);
                        end
                        done_nx = 1'b1;
                        ph      = 0;
                        cnt     = 0;
                     end
                  end
               endcase
            end
         end
         empty = (q.size() == 0);
      end
   end

   task automatic send(input logic [7:0] d, input logic [N-1:0] m);
      logic [N-1:0] pend, acc;
      int b;
      pend = m;
      data = d;
      vld  = m;
      b    = 0;
      while (pend != '0 && b < 400) begin
         @(negedge clk);
         acc = pend & rdy;
         @(posedge clk);
         #1;
         pend = pend & ~acc;
         vld  = vld & ~acc;
         b++;
      end
      if (pend != '0) chk("send_timeout", int'(pend), 0);
      vld = '0;
   endtask

   task automatic wait_idle();
      int b;
      b = 0;
      do begin
         @(negedge clk);
         b++;
      end while ((busy != '0 || qempty != '1) && b < 600);
      chk("idle_reached", int'(b < 600), 1);
      repeat (3) @(negedge clk);
   endtask

   task automatic wait_bit0(input int n);
      int b;
      b = 0;
      while (!(g[0].ph == 1 && g[0].cnt == n) && b < 400) begin
         @(negedge clk);
         b++;
      end
      chk("bit_reached", int'(b < 400), 1);
   endtask

   logic snap;

   initial begin
      // Reset with the baud clock running.
      repeat (3) begin
         @(negedge clk);
         chk("rst_tx", int'(txl), 7);
         chk("rst_ready", int'(rdy), 7);
         chk("rst_busy", int'(busy), 0);
      end
      @(posedge clk);
      #1 rst = 1'b0;
      repeat (6) @(negedge clk);
      chk("idle_tx", int'(txl), 7);

      // 8N1 frame, then even and odd/2-stop parity frames of 0xA5.
      send(8'h55, 3'b001);
      wait_idle();
      send(8'hA5, 3'b110);
      wait_idle();

      // Accept coincides with a tick: that tick must not start the frame.
      begin
         int b;
         b = 0;
         do begin @(negedge clk); b++; end while (!tick_m && b < 20);
         chk("tick_seen", int'(b < 20), 1);
      end
      @(posedge clk);
      repeat (3) @(posedge clk);
      #1;
      send(8'hC3, 3'b001);
      wait_bit0(0);
      chk("accept_to_start", g[0].start_cyc - g[0].acc_cyc, 5);
      wait_idle();

      // Busy rejection: 0xFF offered mid-frame is never taken.
      send(8'h3C, 3'b001);
      repeat (10) @(posedge clk);
      #1;
      data = 8'hFF;
      vld  = 3'b001;
      repeat (12) begin
         @(negedge clk);
         chk("ready_while_busy", int'(rdy[0]), 0);
      end
      @(posedge clk);
      #1 vld = '0;
      wait_idle();

      // Back-to-back with valid held: second accept the cycle after done.
      send(8'h01, 3'b001);
      send(8'h80, 3'b001);
      chk("b2b_accept", g[0].acc_cyc - g[0].done_cyc, 1);
      wait_idle();

      // Reset during data bit 3, then a clean frame.
      send(8'hF0, 3'b001);
      wait_bit0(3);
      @(posedge clk);
      #1 rst = 1'b1;
      @(posedge clk);
      #1 rst = 1'b0;
      @(negedge clk);
      chk("midrst_tx", int'(txl[0]), 1);
      chk("midrst_busy", int'(busy[0]), 0);
      chk("midrst_ready", int'(rdy[0]), 1);
      repeat (8) @(negedge clk);
      send(8'h0F, 3'b001);
      wait_idle();

      // Frozen baud clock holds the line and the frame.
      send(8'h5A, 3'b001);
      wait_bit0(2);
      @(posedge clk);
      #1;
      stuck  = 1'b1;
      len_en = 1'b0;
      @(negedge clk);
      snap = txl[0];
      repeat (20) begin
         @(negedge clk);
         chk("stuck_tx", int'(txl[0]), int'(snap));
         chk("stuck_busy", int'(busy[0]), 1);
      end
      stuck = 1'b0;
      wait_idle();
      len_en = 1'b1;

      chk("leftover", int'(qempty), 7);
      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation exceeded time limit");
      $fatal(1, "watchdog");
   end

endmodule
